// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared bus widths, transfer sizes and arbiter state encodings
package cpu_mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ_I,
    ARB_REQ_D,
    ARB_WAIT_I,
    ARB_WAIT_D
  } arb_state_e;
endpackage

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges CPU inst/data sram-like ports onto one memory port, data first, one outstanding
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);
  arb_state_e    r_state, w_next;
  logic          w_sel_d, w_req, w_wait, w_resp;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_bus_err;
  // State register: reset drops any transaction in flight
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= ARB_IDLE;
    else r_state <= w_next;
  // Next state and grant: data wins in IDLE, grant stays locked until the response
  always_comb begin
    w_next  = r_state;
    w_sel_d = 1'b0;
    w_req   = 1'b0;
    w_wait  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_sel_d = data_req;
        w_req   = data_req | inst_req;
        if (data_req) w_next = mem_addr_ok ? ARB_WAIT_D : ARB_REQ_D;
        else if (inst_req) w_next = mem_addr_ok ? ARB_WAIT_I : ARB_REQ_I;
      end
      ARB_REQ_I: begin
        w_req  = 1'b1;
        w_next = mem_addr_ok ? ARB_WAIT_I : ARB_REQ_I;
      end
      ARB_REQ_D: begin
        w_sel_d = 1'b1;
        w_req   = 1'b1;
        w_next  = mem_addr_ok ? ARB_WAIT_D : ARB_REQ_D;
      end
      ARB_WAIT_I: begin
        w_wait = 1'b1;
        w_next = mem_data_ok ? ARB_IDLE : ARB_WAIT_I;
      end
      ARB_WAIT_D: begin
        w_sel_d = 1'b1;
        w_wait  = 1'b1;
        w_next  = mem_data_ok ? ARB_IDLE : ARB_WAIT_D;
      end
      default: w_next = ARB_IDLE;
    endcase
  end
  // Outputs are gated by resetn so everything reads 0 while reset is held
  assign mem_req      = resetn & w_req;
  assign mem_wr       = mem_req & (w_sel_d ? data_wr : inst_wr);
  assign mem_size     = mem_req ? (w_sel_d ? data_size : inst_size) : '0;
  assign mem_addr     = mem_req ? (w_sel_d ? data_addr : inst_addr) : '0;
  assign mem_wdata    = mem_req ? (w_sel_d ? data_wdata : inst_wdata) : '0;
  assign data_addr_ok = mem_req & w_sel_d & mem_addr_ok;
  assign inst_addr_ok = mem_req & ~w_sel_d & mem_addr_ok;
  assign w_resp       = resetn & w_wait & mem_data_ok;
  assign data_data_ok = w_resp & w_sel_d;
  assign inst_data_ok = w_resp & ~w_sel_d;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign bus_err      = r_bus_err;
  assign w_cnt_nxt    = (r_cnt == LIM) ? r_cnt : r_cnt + 1'b1;
  // Watchdog: counts stalled WAIT cycles, flags a sticky error on reaching the limit
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (!w_wait) r_cnt <= '0;
      else if (!mem_data_ok) r_cnt <= w_cnt_nxt;
      if ((TIMEOUT != 0) && w_wait && !mem_data_ok && (w_cnt_nxt == LIM)) r_bus_err <= 1'b1;
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_cpu_mem_arbiter;
  import cpu_mem_arbiter_pkg::*;
  localparam int TO = 4;
  logic        clk = 1'b0, resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int n_tests = 0, n_fail = 0;
  // transaction-level model: the one transaction owning the bus
  logic m_valid = 0, m_data = 0, m_acc = 0, m_err = 0;
  int   m_wait = 0;
  logic g_data, e_req, e_resp, e_iaok, e_daok, e_idok, e_ddok;
  logic i_acc_last = 0, d_acc_last = 0;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    if (!resetn) begin
      e_req = 0; e_resp = 0; g_data = 0;
    end else begin
      g_data = m_valid ? m_data : data_req;
      e_req  = (m_valid | data_req | inst_req) & ~m_acc;
      e_resp = m_acc & mem_data_ok;
      if (m_valid && !m_acc)
        assert (m_data ? data_req : inst_req) else begin
          n_fail++;
          $error("FAIL protocol: master dropped req before addr_ok");
        end
    end
    e_daok = e_req & g_data & mem_addr_ok;
    e_iaok = e_req & ~g_data & mem_addr_ok;
    e_ddok = e_resp & m_data;
    e_idok = e_resp & ~m_data;
  endtask

  task automatic check_all();
    eval();
    chk("mem_req", mem_req, e_req);
    chk("mem_wr", mem_wr, e_req & (g_data ? data_wr : inst_wr));
    chk("mem_size", mem_size, e_req ? (g_data ? data_size : inst_size) : 2'd0);
    chk("mem_addr", mem_addr, e_req ? (g_data ? data_addr : inst_addr) : 32'd0);
    chk("mem_wdata", mem_wdata, e_req ? (g_data ? data_wdata : inst_wdata) : 32'd0);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_data_ok", data_data_ok, e_ddok);
    chk("inst_data_ok", inst_data_ok, e_idok);
    chk("data_rdata", data_rdata, e_ddok ? mem_rdata : 32'd0);
    chk("inst_rdata", inst_rdata, e_idok ? mem_rdata : 32'd0);
    chk("bus_err", bus_err, resetn & m_err);
  endtask

  task automatic advance();
    eval();
    i_acc_last = e_iaok;
    d_acc_last = e_daok;
    if (!resetn) begin
      m_valid = 0; m_acc = 0; m_wait = 0; m_err = 0;
    end else if (e_resp) begin
      m_valid = 0; m_acc = 0;
    end else if (e_req) begin
      m_valid = 1; m_data = g_data; m_acc = mem_addr_ok; m_wait = 0;
    end else if (m_acc) begin
      m_wait++;
      if (m_wait >= TO) m_err = 1;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic set_inst(input logic rq, input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    inst_req = rq; inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd;
  endtask

  task automatic set_data(input logic rq, input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_req = rq; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
  endtask

  task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rd);
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
  endtask

  initial begin
    resetn = 0;
    set_inst(0, 0, SIZE_WORD, 0, 0);
    set_data(1, 0, SIZE_WORD, 32'h1000, 0);
    set_mem(1, 1, 32'h55);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    cyc(); cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 0, 0);
    resetn = 1;
    #1;
    chk("rst_bus_err", bus_err, 0);
    cyc();
    // 1: single data read, response three cycles after accept
    set_data(1, 0, SIZE_WORD, 32'h1000, 0);
    set_mem(1, 0, 0);
    #1;
    chk("t1_daok", data_addr_ok, 1);
    chk("t1_addr", mem_addr, 32'h1000);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 0, 0);
    cyc(); cyc();
    set_mem(0, 1, 32'hDEADBEEF);
    #1;
    chk("t1_ddok", data_data_ok, 1);
    chk("t1_rdata", data_rdata, 32'hDEADBEEF);
    chk("t1_inst_rdata", inst_rdata, 0);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // 2: simultaneous requests, data first then inst
    set_inst(1, 0, SIZE_WORD, 32'h400, 0);
    set_data(1, 0, SIZE_WORD, 32'h1004, 0);
    set_mem(1, 0, 0);
    #1;
    chk("t2_daok", data_addr_ok, 1);
    chk("t2_iaok", inst_addr_ok, 0);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(1, 1, 32'hA5A5A5A5);
    #1;
    chk("t2_ddok", data_data_ok, 1);
    chk("t2_no_same_cycle_grant", inst_addr_ok, 0);
    cyc();
    set_mem(1, 0, 0);
    #1;
    chk("t2_iaok_t2", inst_addr_ok, 1);
    chk("t2_iaddr", mem_addr, 32'h400);
    cyc();
    set_inst(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 1, 32'h12345678);
    #1;
    chk("t2_idok", inst_data_ok, 1);
    chk("t2_irdata", inst_rdata, 32'h12345678);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // 3: inst locked while memory stalls, data waits for inst response
    set_inst(1, 0, SIZE_WORD, 32'h800, 0);
    cyc();
    set_data(1, 0, SIZE_HALF, 32'h3000, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_locked_addr", mem_addr, 32'h800);
      cyc();
    end
    mem_addr_ok = 1;
    #1;
    chk("t3_iaok", inst_addr_ok, 1);
    chk("t3_daok", data_addr_ok, 0);
    cyc();
    set_inst(0, 0, SIZE_WORD, 0, 0);
    mem_addr_ok = 0;
    #1;
    chk("t3_wait_req", mem_req, 0);
    cyc();
    set_mem(1, 1, 32'h77);
    #1;
    chk("t3_idok", inst_data_ok, 1);
    chk("t3_no_grant", data_addr_ok, 0);
    cyc();
    set_mem(1, 0, 0);
    #1;
    chk("t3_daok_late", data_addr_ok, 1);
    chk("t3_daddr", mem_addr, 32'h3000);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 1, 32'h88);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // 4: byte write forwarded verbatim
    set_data(1, 1, SIZE_BYTE, 32'h2003, 32'hAB);
    set_mem(1, 0, 0);
    #1;
    chk("t4_wr", mem_wr, 1);
    chk("t4_size", mem_size, SIZE_BYTE);
    chk("t4_addr", mem_addr, 32'h2003);
    chk("t4_wdata", mem_wdata, 32'hAB);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 1, 32'h0BADF00D);
    #1;
    chk("t4_ddok", data_data_ok, 1);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // 5: watchdog fires after the fourth stalled WAIT cycle and stays set
    set_data(1, 0, SIZE_WORD, 32'h5000, 0);
    set_mem(1, 0, 0);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    mem_addr_ok = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("t5_err_early", bus_err, 0);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_err_set", bus_err, 1);
      cyc();
    end
    set_mem(0, 1, 32'hCAFE);
    #1;
    chk("t5_late_ddok", data_data_ok, 1);
    cyc();
    set_mem(0, 0, 0);
    #1;
    chk("t5_sticky", bus_err, 1);
    cyc();
    // 6: async reset mid-WAIT_D, then stray response ignored
    set_data(1, 0, SIZE_WORD, 32'h6000, 0);
    set_mem(1, 0, 0);
    cyc();
    set_data(0, 0, SIZE_WORD, 0, 0);
    mem_addr_ok = 0;
    cyc();
    set_inst(1, 0, SIZE_WORD, 32'h40, 0);
    set_data(1, 0, SIZE_WORD, 32'h44, 0);
    set_mem(1, 1, 32'hFFFF);
    resetn = 0;
    #1;
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_ddok", data_data_ok, 0);
    chk("t6_rst_daok", data_addr_ok, 0);
    chk("t6_rst_err", bus_err, 0);
    cyc();
    set_inst(0, 0, SIZE_WORD, 0, 0);
    set_data(0, 0, SIZE_WORD, 0, 0);
    set_mem(0, 1, 32'h1234);
    resetn = 1;
    #1;
    chk("t6_stray_ddok", data_data_ok, 0);
    chk("t6_stray_idok", inst_data_ok, 0);
    cyc();
    set_mem(0, 0, 0);
    cyc();
    // random traffic from protocol-abiding masters and a random-latency memory
    for (int k = 0; k < 4; k++) begin
      resetn = 0;
      set_inst(0, 0, SIZE_WORD, 0, 0);
      set_data(0, 0, SIZE_WORD, 0, 0);
      set_mem(0, 0, 0);
      cyc();
      resetn = 1;
      cyc();
      for (int c = 0; c < 250; c++) begin
        if (!inst_req || i_acc_last)
          set_inst($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 2)), $urandom, $urandom);
        if (!data_req || d_acc_last)
          set_data($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), $urandom, $urandom);
        set_mem($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom);
        cyc();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
